// File: rtl/eeg_oram_acc_bank.sv
// eeg_oram_acc_bank
// Output RAM bank: CH_NUM independent channels, each a DEPTH x DAT_DW 1R1W
// array. Writes either overwrite or saturating-accumulate (signed RMW with a
// one-entry forward register). Reads go through a 2-entry skid FIFO carrying
// a last tag. A shared sequencer zeroes all channels on request.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   din_vld/rdy/acc       per-channel write handshake and accumulate select
//   din_add, din_dat      per-channel write address / data (flattened slices)
//   add_vld/rdy/lst/add   per-channel read-address handshake, tag, address
//   dat_vld/rdy/lst/dat   per-channel read-data handshake, tag, data
//   clr_req               start-clear pulse (honoured only when idle)
//   clr_busy, clr_done    clear in progress / one-cycle completion pulse
//   dbg_state             clear sequencer state, for observation
//
// Handshake rule for every valid/ready pair: a transfer happens on a rising
// clock edge where both valid and ready are high; valid must not depend on
// ready, and ready may depend on valid only where noted (add_rdy drops when
// the same channel presents an accumulate write, since that write needs the
// single array read port).
module eeg_oram_acc_bank #(
  parameter int CH_NUM = 16,
  parameter int ADD_AW = 8,
  parameter int DAT_DW = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CH_NUM-1:0]        din_vld,
  output logic [CH_NUM-1:0]        din_rdy,
  input  logic [CH_NUM-1:0]        din_acc,
  input  logic [CH_NUM*ADD_AW-1:0] din_add,
  input  logic [CH_NUM*DAT_DW-1:0] din_dat,
  input  logic [CH_NUM-1:0]        add_vld,
  input  logic [CH_NUM-1:0]        add_lst,
  output logic [CH_NUM-1:0]        add_rdy,
  input  logic [CH_NUM*ADD_AW-1:0] add_add,
  output logic [CH_NUM-1:0]        dat_vld,
  output logic [CH_NUM-1:0]        dat_lst,
  input  logic [CH_NUM-1:0]        dat_rdy,
  output logic [CH_NUM*DAT_DW-1:0] dat_dat,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done,
  output logic [1:0]               dbg_state
);

  localparam int DEPTH = 1 << ADD_AW;
  localparam logic [DAT_DW-1:0] W_MAX = {1'b0, {(DAT_DW-1){1'b1}}};
  localparam logic [DAT_DW-1:0] W_MIN = {1'b1, {(DAT_DW-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLR   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADD_AW-1:0] r_clr_cnt;
  logic              r_clr_done;
  logic              w_idle;
  logic              w_clr_wr;
  logic              w_clr_last;

  // ---------------------------------------------------------------------------
  // Clear sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_clr_cnt  <= '0;
      r_clr_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_done <= w_clr_last;
      if (r_state == ST_CLR) r_clr_cnt <= r_clr_cnt + 1'b1;
      else                   r_clr_cnt <= '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idle      = 1'b0;
    w_clr_wr    = 1'b0;
    w_clr_last  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_idle = 1'b1;
        if (clr_req) w_state_nxt = ST_DRAIN;
      end
      // One dead cycle lets the last accepted write retire from S2 so the
      // array write port is free for the clear sweep.
      ST_DRAIN: w_state_nxt = ST_CLR;
      ST_CLR: begin
        w_clr_wr   = 1'b1;
        w_clr_last = &r_clr_cnt;
        if (w_clr_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign clr_busy  = (r_state != ST_IDLE);
  assign clr_done  = r_clr_done;
  assign dbg_state = r_state;

  // ---------------------------------------------------------------------------
  // Channels
  // ---------------------------------------------------------------------------
  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    logic [DAT_DW-1:0] r_mem [DEPTH];

    logic              w_wr_fire;
    logic              w_wr_acc;
    logic              w_rd_fire;
    logic              w_pop;
    logic              w_fwd_hit;
    logic [ADD_AW-1:0] w_rd_addr;
    logic [DAT_DW-1:0] w_rd_data;
    logic [DAT_DW-1:0] w_old;
    logic [DAT_DW:0]   w_sum;
    logic [DAT_DW-1:0] w_sat;
    logic [DAT_DW-1:0] w_new;

    logic              r_s2_vld;
    logic              r_s2_acc;
    logic [ADD_AW-1:0] r_s2_add;
    logic [DAT_DW-1:0] r_s2_dat;
    logic [DAT_DW-1:0] r_s2_old;
    logic              r_fwd_vld;
    logic [ADD_AW-1:0] r_fwd_add;
    logic [DAT_DW-1:0] r_fwd_val;

    logic [DAT_DW-1:0] r_fifo_dat [2];
    logic              r_fifo_lst [2];
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_cnt;

    assign w_wr_fire = din_vld[c] & w_idle;
    assign w_wr_acc  = w_wr_fire & din_acc[c];
    assign din_rdy[c] = w_idle;
    // The FIFO slot itself is the array read register, so a read accepted
    // now occupies a slot at the next edge; no separate in-flight term.
    assign add_rdy[c] = w_idle & (r_cnt < 2'd2) & ~w_wr_acc;
    assign w_rd_fire  = add_vld[c] & add_rdy[c];

    // Single array read port: the accumulate read wins over a user read.
    assign w_rd_addr = w_wr_acc ? din_add[c*ADD_AW +: ADD_AW]
                                : add_add[c*ADD_AW +: ADD_AW];
    assign w_rd_data = r_mem[w_rd_addr];

    // S2: the write committed in the previous cycle is not yet seen by the
    // (read-first) array read issued in that same cycle, so take it from
    // the forward register instead.
    assign w_fwd_hit = r_fwd_vld & (r_fwd_add == r_s2_add);
    assign w_old     = w_fwd_hit ? r_fwd_val : r_s2_old;
    assign w_sum     = {w_old[DAT_DW-1], w_old} + {r_s2_dat[DAT_DW-1], r_s2_dat};

    always_comb begin
      w_sat = w_sum[DAT_DW-1:0];
      if (w_sum[DAT_DW] != w_sum[DAT_DW-1]) w_sat = w_sum[DAT_DW] ? W_MIN : W_MAX;
    end

    assign w_new = r_s2_acc ? w_sat : r_s2_dat;

    always_ff @(posedge clk) begin
      if (r_s2_vld)      r_mem[r_s2_add]  <= w_new;
      else if (w_clr_wr) r_mem[r_clr_cnt] <= '0;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_s2_vld  <= 1'b0;
        r_fwd_vld <= 1'b0;
      end else begin
        r_s2_vld  <= w_wr_fire;
        r_fwd_vld <= r_s2_vld & ~w_clr_last;
      end
      if (w_wr_fire) begin
        r_s2_add <= din_add[c*ADD_AW +: ADD_AW];
        r_s2_dat <= din_dat[c*DAT_DW +: DAT_DW];
        r_s2_acc <= din_acc[c];
      end
      if (w_wr_acc) r_s2_old <= w_rd_data;
      r_fwd_add <= r_s2_add;
      r_fwd_val <= w_new;
    end

    // 2-entry skid FIFO on the read side.
    assign w_pop = (r_cnt != 2'd0) & dat_rdy[c];

    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt  <= 2'd0;
        r_wptr <= 1'b0;
        r_rptr <= 1'b0;
      end else begin
        if (w_rd_fire) begin
          r_fifo_dat[r_wptr] <= w_rd_data;
          r_fifo_lst[r_wptr] <= add_lst[c];
          r_wptr             <= ~r_wptr;
        end
        if (w_pop) r_rptr <= ~r_rptr;
        r_cnt <= r_cnt + {1'b0, w_rd_fire} - {1'b0, w_pop};
      end
    end

    assign dat_vld[c] = (r_cnt != 2'd0);
    assign dat_lst[c] = dat_vld[c] ? r_fifo_lst[r_rptr] : 1'b0;
    assign dat_dat[c*DAT_DW +: DAT_DW] = dat_vld[c] ? r_fifo_dat[r_rptr] : '0;
  end

endmodule
